// File: rtl/pipeline_fetch_pkg.sv
// Shared fetch-stage types: instruction width, NOP encoding, buffered entry, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // One instruction as handed to decode: where it came from and what it is.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Fetch addresses are always word aligned; low bits of a target are ignored.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/pipeline_fetch_if.sv
// Bundle of fetch-stage signals: imem request/response, redirect, decode handshake.
// Latency: n/a (wires only).
// Backpressure: imem_req_ready throttles requests, dec_ready throttles delivery.
interface pipeline_fetch_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  // Fetch stage side.
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, dec_ready
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/pipeline_fetch_fifo.sv
// Small register-based FIFO with synchronous clear and occupancy count.
// Latency: push visible at head next cycle; head read is combinational from storage.
// Backpressure: push ignored when full (unless popping), pop ignored when empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  input  logic                   clear,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop) && !clear;
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch: owns the PC, issues imem requests, pairs responses with PCs for decode.
// Latency: imem response at cycle T is presented on out_* at T+1.
// Backpressure: requests only while outstanding+buffered < FIFO_DEPTH; out_* hold while !dec_ready.
module pipeline_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             rst,
  pipeline_fetch_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_BOOT  = BOOT;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] last_pc_q;
  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   drop_cnt_d;
  logic [CW-1:0]   out_count;
  logic [CW-1:0]   pend_count;
  logic [CW:0]     inflight_sum;

  logic            credit_ok;
  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_drop;
  logic            rsp_keep;
  logic            out_fire;
  logic            redirect;

  logic            pend_full;
  logic            pend_empty;
  logic [XLEN-1:0] pend_pc;
  logic            out_full;
  logic            out_empty;
  logic [$bits(fetch_entry_t)-1:0] out_head_raw;
  fetch_entry_t    out_head;
  fetch_entry_t    out_push_entry;
  logic            unused_pend_count;

  assign redirect     = bus.redirect_valid;
  assign inflight_sum = {1'b0, outstanding_q} + {1'b0, out_count};
  assign credit_ok    = (inflight_sum < (CW+1)'(FIFO_DEPTH)) && !pend_full;

  assign bus.imem_req_valid = (state_q != ST_BOOT) && !redirect && credit_ok;
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Every response retires the oldest pending PC; it is kept only if not stale.
  assign rsp_ok   = bus.imem_rsp_valid && !pend_empty;
  assign rsp_drop = rsp_ok && (drop_cnt_q != '0);
  assign rsp_keep = rsp_ok && (drop_cnt_q == '0) && !redirect && !out_full;

  assign out_head       = fetch_entry_t'(out_head_raw);
  assign out_push_entry = '{pc: pend_pc, inst: bus.imem_rsp_data};

  assign bus.out_valid = !out_empty && !redirect;
  assign bus.out_inst  = out_empty ? NOP_INST  : out_head.inst;
  assign bus.out_pc    = out_empty ? last_pc_q : out_head.pc;
  assign out_fire      = bus.out_valid && bus.dec_ready;

  // Occupancy of the pending queue mirrors outstanding_q and is not needed here.
  assign unused_pend_count = ^pend_count;

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pend_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_ok),
    .pop_data  (pend_pc),
    .clear     (1'b0),
    .full      (pend_full),
    .empty     (pend_empty),
    .count     (pend_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (out_push_entry),
    .pop       (out_fire),
    .pop_data  (out_head_raw),
    .clear     (redirect),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  // On redirect every request still in flight becomes stale, minus one retiring now.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      drop_cnt_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Sequencing: one BOOT cycle, then RUN, with DRAIN while stale responses are due.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_DRAIN: state_d = (drop_cnt_d == '0) ? ST_RUN : ST_DRAIN;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  // PC, counters, FSM and last-delivered PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      last_pc_q     <= RESET_PC;
      state_q       <= ST_BOOT;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (redirect) begin
        pc_q <= word_align(bus.redirect_pc);
      end else if (req_fire) begin
        pc_q <= pc_q + XLEN'(4);
      end
      if (out_fire) last_pc_q <= out_head.pc;
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(rsp_ok);
      drop_cnt_q    <= drop_cnt_d;
      state_q       <= state_d;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Self-checking bench for pipeline_fetch: directed phases followed by random traffic.
// Reference: epoch-tagged request list plus a decode-visible queue of {pc, inst}.
// Second instance exercises PC wrap from RESET_PC = 0xFFFF_FFFC.
module tb_pipeline_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_fetch_if bus ();
  pipeline_fetch_if bus2 ();

  pipeline_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_fetch #(.RESET_PC(RPC2), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t         req_q[$];   // accepted by imem, response not yet returned
  fetch_entry_t out_q[$];   // what decode should see, oldest first
  int           epoch, cyc_no, since_rst, lat;
  int           checks, errors;
  int           pops_after_redir;
  logic [31:0]  first_pc_after_redir;
  logic [31:0]  exp_req, last_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    req_q.delete();
    out_q.delete();
    epoch     = 0;
    exp_req   = RPC;
    last_pc   = RPC;
    since_rst = 0;
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit rr, input bit dr, input bit redir, input logic [31:0] tgt);
    bit   rsp, exp_rv, exp_ov, fire, pop;
    req_t r;
    rsp = (req_q.size() != 0) && (req_q[0].due <= cyc_no);
    bus.imem_req_ready = rr;
    bus.dec_ready      = dr;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? inst_of(req_q[0].addr) : $urandom;
    #1;
    exp_rv = (since_rst != 0) && !redir && ((req_q.size() + out_q.size()) < DEPTH);
    exp_ov = (out_q.size() != 0) && !redir;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", bus.imem_req_addr, exp_req);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (!redir) begin
      if (out_q.size() != 0) begin
        chk("out_pc", bus.out_pc, out_q[0].pc);
        chk("out_inst", bus.out_inst, out_q[0].inst);
      end else begin
        chk("idle_out_pc", bus.out_pc, last_pc);
        chk("idle_out_inst", bus.out_inst, NOP_INST);
      end
    end
    if (since_rst < 4) begin
      chk("wrap_req_valid", 32'(bus2.imem_req_valid), 32'(since_rst == 1 || since_rst == 2));
      if (since_rst == 1) chk("wrap_addr0", bus2.imem_req_addr, RPC2);
      if (since_rst == 2) chk("wrap_addr1", bus2.imem_req_addr, RPC2 + 32'd4);
    end
    fire = exp_rv && rr;
    pop  = exp_ov && dr;
    if (pop) begin
      if (pops_after_redir == 0) first_pc_after_redir = bus.out_pc;
      pops_after_redir++;
      last_pc = out_q[0].pc;
      void'(out_q.pop_front());
    end
    if (rsp) begin
      r = req_q.pop_front();
      if (r.epoch == epoch && !redir) out_q.push_back('{pc: r.addr, inst: inst_of(r.addr)});
    end
    if (redir) begin
      out_q.delete();
      epoch++;
      exp_req          = tgt & ~32'h3;
      pops_after_redir = 0;
    end
    if (fire) begin
      req_q.push_back('{addr: exp_req, epoch: epoch, due: cyc_no + lat});
      exp_req = exp_req + 32'd4;
    end
    cyc_no++;
    since_rst++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    cyc_no           = 0;
    lat              = 1;
    pops_after_redir = 0;
    first_pc_after_redir = 32'h0;
    bus2.imem_req_ready = 1'b1;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = 32'h0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.dec_ready      = 1'b1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset();

    // Streaming with a 1-cycle imem and decode always ready.
    lat = 1;
    repeat (12) cyc(1, 1, 0, 32'h0);

    // Decode stall: credit caps outstanding+buffered, outputs hold, then drain in order.
    repeat (5) cyc(1, 0, 0, 32'h0);
    repeat (8) cyc(1, 1, 0, 32'h0);

    // Two requests in flight at 0x10/0x14 with a 3-cycle imem, then redirect to 0x100.
    lat = 3;
    cyc(1, 1, 1, 32'h10);
    for (int i = 0; i < 20; i++) begin
      if (req_q.size() == 2 && req_q[0].addr == 32'h10 && req_q[1].addr == 32'h14) break;
      cyc(1, 1, 0, 32'h0);
    end
    chk("t3_inflight_pair", req_q.size(), 2);
    cyc(1, 1, 1, 32'h100);
    repeat (14) cyc(1, 1, 0, 32'h0);
    chk("t3_delivered", 32'(pops_after_redir != 0), 32'd1);
    chk("t3_first_pc", first_pc_after_redir, 32'h100);

    // Redirect to an unaligned target with nothing in flight.
    for (int i = 0; i < 20; i++) begin
      if (req_q.size() == 0 && out_q.size() == 0) break;
      cyc(0, 1, 0, 32'h0);
    end
    chk("t4_pipe_empty", req_q.size() + out_q.size(), 0);
    lat = 1;
    cyc(1, 1, 1, 32'h203);
    repeat (8) cyc(1, 1, 0, 32'h0);
    chk("t4_first_pc", first_pc_after_redir, 32'h200);

    // imem not ready: address held, buffer drains, then resume.
    repeat (4) cyc(0, 1, 0, 32'h0);
    repeat (6) cyc(1, 1, 0, 32'h0);

    // Reset with items buffered; the following BOOT cycle is checked inside cyc.
    repeat (4) cyc(1, 0, 0, 32'h0);
    do_reset();
    repeat (10) cyc(1, 1, 0, 32'h0);

    // Random traffic: backpressure on both sides, variable latency, redirects anywhere.
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 0) lat = int'($urandom_range(1, 3));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          (since_rst != 0) && ($urandom_range(0, 15) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
